// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- runtime-configurable UART transmitter.
//
// Takes one word per valid/ready handshake and sends it LSB-first on tx.
// Each bit lasts OVERSAMPLE pulses of the shared b_tick strobe. Each frame
// can carry 5..DATA_W data bits, none/odd/even parity and 1 or 2 stop bits.
// The frame settings are captured together with the word.
//
// Ports
//   clk       system clock
//   a_resetn  synchronous reset, active HIGH (the name is historical)
//   b_tick    one-clk oversample strobe from the baud generator
//   tx_valid  word available on tx_data
//   tx_ready  block can accept a word (idle and not in reset)
//   tx_data   word; bits at and above the effective length are ignored
//   tx_len    data bits per frame; values below 5 become 5, values above DATA_W become DATA_W
//   parity    00 none, 01 odd, 10 even, 11 none
//   stop2     0 = one stop bit, 1 = two stop bits
//   tx        serial line output, registered, idles high
//   busy      frame in progress
//   tx_done   one-clk pulse after the final stop bit completes
module uart_tx_cfg #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              a_resetn,
    input  logic              b_tick,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [3:0]        tx_len,
    input  logic [1:0]        parity,
    input  logic              stop2,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned         TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]          LEN_MIN   = 4'd5;
    localparam logic [3:0]          LEN_MAX   = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [3:0]          len_q, len_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                stop2_q, stop2_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic                accept;
    logic                bit_end;
    logic [3:0]          len_clamped;
    logic                data_xor;
    logic                parity_bit;
    logic [15:0]         data_ext;

    assign tx_ready = (state_q == S_IDLE) && !a_resetn;
    assign accept   = tx_valid && tx_ready;
    assign bit_end  = b_tick && (tick_q == TICK_LAST);
    assign busy     = (state_q != S_IDLE);
    assign tx       = tx_q;
    assign tx_done  = done_q;

    always_comb begin
        if (tx_len < LEN_MIN) begin
            len_clamped = LEN_MIN;
        end else if (tx_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end else begin
            len_clamped = tx_len;
        end
    end

    // Only the first len_q latched bits take part in the parity.
    always_comb begin
        data_xor = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (4'(i) < len_q) begin
                data_xor = data_xor ^ data_q[i];
            end
        end
        parity_bit = par_odd_q ? ~data_xor : data_xor;
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        data_d    = data_q;
        len_d     = len_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        done_d    = 1'b0;

        // tick_cnt advances only on b_tick while a frame is running.
        if (state_q != S_IDLE && b_tick) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (accept) begin
                    data_d    = tx_data;
                    len_d     = len_clamped;
                    par_en_d  = (parity == 2'b01) || (parity == 2'b10);
                    par_odd_d = (parity == 2'b01);
                    stop2_d   = stop2;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_q >= len_q) begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end else if (bit_end) begin
                    if (bit_q == 4'(len_q - 4'd1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // tx is decoded from the next state so the line register changes on the
    // same edge as the state, keeping tx glitch-free and aligned to bit edges.
    assign data_ext = 16'(data_d);

    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_ext[bit_d];
            S_PARITY: tx_d = parity_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_resetn) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            len_q     <= LEN_MIN;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            len_q     <= len_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       a_resetn = 1'b1;
    logic       b_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] tx_len = 4'd8;
    logic [1:0] parity = 2'b00;
    logic       stop2 = 1'b0;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;
    int tick_period = 1;
    int tick_div = 0;

    uart_tx_cfg #(.DATA_W(8), .OVERSAMPLE(16)) dut (
        .clk      (clk),
        .a_resetn (a_resetn),
        .b_tick   (b_tick),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_len   (tx_len),
        .parity   (parity),
        .stop2    (stop2),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // b_tick: high one clk out of every tick_period clks (always high when 1).
    always @(negedge clk) begin
        b_tick = (tick_div == 0);
        tick_div = (tick_div + 1 >= tick_period) ? 0 : tick_div + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sends one word and follows the frame tick by tick. Expected line bits
    // come from the hand-computed length/parity/stop arguments.
    task automatic run_frame(input logic [7:0] d, input logic [3:0] len_in,
                             input logic [1:0] par, input logic st2,
                             input int exp_len, input int exp_has_p,
                             input logic exp_p, input int exp_stops,
                             input bit keep_valid, input logic [7:0] next_d,
                             input string name, output int waited);
        logic [15:0] bits;
        int n, c, cyc, budget, bad_c;
        bit bad, first;
        logic bad_tx, bad_busy, bad_rdy, bad_done, bad_exp;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < exp_len; i++) bits[1 + i] = d[i];
        n = 1 + exp_len;
        if (exp_has_p != 0) begin
            bits[n] = exp_p;
            n++;
        end
        n += exp_stops;

        tx_data = d; tx_len = len_in; parity = par; stop2 = st2; tx_valid = 1'b1;
        waited = 0;
        while (!tx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: tx_ready=%b required 1", name, tx_ready);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);

        c = 0; cyc = 0; bad = 0; first = 1; bad_c = 0;
        bad_tx = 0; bad_busy = 0; bad_rdy = 0; bad_done = 0; bad_exp = 0;
        budget = n * 16 * tick_period + 20;
        forever begin
            @(negedge clk);
            if (first) begin
                first = 0;
                if (keep_valid) begin
                    tx_data = next_d;
                end else begin
                    tx_valid = 1'b0;
                    tx_data = ~d;
                    tx_len = ~len_in;
                    parity = ~par;
                    stop2 = ~st2;
                end
            end
            if (c == n * 16) break;
            if (!bad && (tx !== bits[c / 16] || busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0)) begin
                bad = 1; bad_c = c; bad_tx = tx; bad_busy = busy;
                bad_rdy = tx_ready; bad_done = tx_done; bad_exp = bits[c / 16];
            end
            if (cyc > budget) break;
            @(posedge clk);
            if (b_tick) c++;
            cyc++;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s bits: tick %0d tx=%b busy=%b tx_ready=%b tx_done=%b, required tx=%b busy=1 tx_ready=0 tx_done=0",
                     name, bad_c, bad_tx, bad_busy, bad_rdy, bad_done, bad_exp);
        end
        checks++;
        if (c != n * 16 || tx_done !== 1'b1 || tx !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s done: ticks=%0d tx_done=%b tx=%b tx_ready=%b, required ticks=%0d tx_done=1 tx=1 tx_ready=1",
                     name, c, tx_done, tx, tx_ready, n * 16);
        end
        if (!keep_valid) begin
            @(negedge clk);
            checks++;
            if (tx_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after: tx_done=%b tx=%b busy=%b, required 0 1 0", name, tx_done, tx, busy);
            end
        end
    endtask

    task automatic test_reset();
        a_resetn = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: tx=%b busy=%b tx_done=%b tx_ready=%b, required 1 0 0 0",
                     tx, busy, tx_done, tx_ready);
        end
        a_resetn = 1'b0;
        tx_valid = 1'b0;
        #1;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tx_ready=%b busy=%b tx=%b, required 1 0 1", tx_ready, busy, tx);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int w;
        run_frame(8'h55, 4'd8, 2'b00, 1'b0, 8, 0, 1'b0, 1, 0, 8'h00, "basic_55", w);
    endtask

    task automatic test_parity();
        int w;
        run_frame(8'h07, 4'd8, 2'b01, 1'b0, 8, 1, 1'b0, 1, 0, 8'h00, "odd_07", w);
        run_frame(8'h07, 4'd8, 2'b10, 1'b0, 8, 1, 1'b1, 1, 0, 8'h00, "even_07", w);
        run_frame(8'h07, 4'd8, 2'b11, 1'b0, 8, 0, 1'b0, 1, 0, 8'h00, "reserved_07", w);
    endtask

    task automatic test_short_len();
        int w;
        run_frame(8'hFF, 4'd5, 2'b10, 1'b0, 5, 1, 1'b1, 1, 0, 8'h00, "len5_FF_even", w);
        run_frame(8'hE3, 4'd5, 2'b10, 1'b0, 5, 1, 1'b0, 1, 0, 8'h00, "len5_E3_even", w);
        run_frame(8'hE3, 4'd5, 2'b01, 1'b0, 5, 1, 1'b1, 1, 0, 8'h00, "len5_E3_odd", w);
    endtask

    task automatic test_len_clamp();
        int w;
        run_frame(8'hFF, 4'd2, 2'b00, 1'b1, 5, 0, 1'b0, 2, 0, 8'h00, "len2_stop2", w);
        run_frame(8'h81, 4'd15, 2'b00, 1'b0, 8, 0, 1'b0, 1, 0, 8'h00, "len15_81", w);
    endtask

    task automatic test_tick_gaps();
        int w;
        tick_period = 3;
        run_frame(8'hC6, 4'd6, 2'b01, 1'b1, 6, 1, 1'b1, 2, 0, 8'h00, "gaps_C6", w);
        tick_period = 1;
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        run_frame(8'hA5, 4'd8, 2'b00, 1'b0, 8, 0, 1'b0, 1, 1, 8'h3C, "b2b_A5", w1);
        run_frame(8'h3C, 4'd8, 2'b00, 1'b0, 8, 0, 1'b0, 1, 0, 8'h00, "b2b_3C", w2);
        checks++;
        if (w2 != 0) begin
            errors++;
            $display("FAIL b2b_gap: extra idle clks before second accept=%0d required 0", w2);
        end
    endtask

    task automatic test_reset_midframe();
        int c, cyc, w;
        tx_data = 8'h55; tx_len = 4'd8; parity = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
        cyc = 0;
        while (!tx_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        c = 0; cyc = 0;
        @(negedge clk);
        tx_valid = 1'b0;
        while (c < 4 * 16 + 8 && cyc < 400) begin
            @(posedge clk);
            if (b_tick) c++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_bit3: tx=%b busy=%b ticks=%0d, required tx=0 busy=1 ticks=72", tx, busy, c);
        end
        a_resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: tx=%b busy=%b tx_ready=%b tx_done=%b, required 1 0 0 0",
                     tx, busy, tx_ready, tx_done);
        end
        @(negedge clk);
        a_resetn = 1'b0;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL midframe_release: tx_ready=%b required 1", tx_ready);
        end
        run_frame(8'h81, 4'd8, 2'b00, 1'b0, 8, 0, 1'b0, 1, 0, 8'h00, "after_reset_81", w);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_short_len();
        test_len_clamp();
        test_tick_gaps();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
